// File: rtl/scan_mux.sv
// -----------------------------------------------------------------------------
// scan_mux
//   N-channel registered multiplexer with two modes:
//     MANUAL (mode=0): sel_in picks the channel routed to y.
//     SCAN   (mode=1): cur_sel steps through the channels enabled in ch_mask.
//                      Each channel is held for DWELL cycles per visit.
//   All outputs are registered, so y follows din/sel_in one clock later.
//
// Ports
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   en       1 = active, 0 = hold state (y_valid and wrap drop to 0)
//   mode     0 = MANUAL, 1 = SCAN
//   sel_in   MANUAL channel select
//   ch_mask  SCAN enable per channel (bit i = channel i)
//   din      flattened channel data, channel i = din[i*DW +: DW]
//   y        registered selected data
//   y_valid  y holds valid channel data
//   cur_sel  channel currently selected
//   wrap     1-cycle pulse when SCAN wraps to a lower-or-equal channel index
//   sel_err  MANUAL sel_in out of range (registered)
// -----------------------------------------------------------------------------
module scan_mux #(
  parameter  int N_CH  = 4,
  parameter  int DW    = 8,
  parameter  int DWELL = 4,
  localparam int SEL_W = $clog2(N_CH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               mode,
  input  logic [SEL_W-1:0]   sel_in,
  input  logic [N_CH-1:0]    ch_mask,
  input  logic [N_CH*DW-1:0] din,
  output logic [DW-1:0]      y,
  output logic               y_valid,
  output logic [SEL_W-1:0]   cur_sel,
  output logic               wrap,
  output logic               sel_err
);

  localparam int DCW = $clog2(DWELL + 1);

  typedef enum logic {
    ST_MANUAL = 1'b0,
    ST_SCAN   = 1'b1
  } state_t;

  state_t           r_state,     w_state_nxt;
  logic [DW-1:0]    r_y,         w_y_nxt;
  logic             r_y_valid,   w_y_valid_nxt;
  logic [SEL_W-1:0] r_cur_sel,   w_cur_sel_nxt;
  logic             r_wrap,      w_wrap_nxt;
  logic             r_sel_err,   w_sel_err_nxt;
  logic [DCW-1:0]   r_dwell_cnt, w_dwell_nxt;

  logic [DW-1:0]    w_cur_data;
  logic [DW-1:0]    w_sel_data;
  logic             w_cur_mask;
  logic             w_sel_ok;
  logic [SEL_W-1:0] w_hi_idx;
  logic [SEL_W-1:0] w_lo_idx;
  logic             w_hi_found;
  logic [SEL_W-1:0] w_next_sel;
  logic [DCW-1:0]   w_dwell_eff;
  logic             w_dwell_last;

  // Channel lookup by comparison rather than variable part-select, so an
  // unused select code (non-pow2 N_CH) yields zero data instead of X.
  // NOTE: every variable gets a default before the loop; otherwise a path that
  // skips assignment would infer a latch.
  always_comb begin
    w_cur_data = '0;
    w_sel_data = '0;
    w_cur_mask = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (r_cur_sel == SEL_W'(i)) begin
        w_cur_data = din[i*DW +: DW];
        w_cur_mask = ch_mask[i];
      end
      if (sel_in == SEL_W'(i)) begin
        w_sel_data = din[i*DW +: DW];
      end
    end
  end

  // One extra bit keeps the range test meaningful when N_CH is a power of two.
  assign w_sel_ok = ({1'b0, sel_in} < (SEL_W + 1)'(N_CH));

  // Next enabled channel, cyclic ascending from cur_sel+1. Walking downward and
  // overwriting leaves the lowest hit in each half: the lowest enabled index
  // above cur_sel, else the lowest at or below it (a wrap).
  always_comb begin
    w_hi_idx   = '0;
    w_lo_idx   = '0;
    w_hi_found = 1'b0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (ch_mask[i]) begin
        if (SEL_W'(i) > r_cur_sel) begin
          w_hi_idx   = SEL_W'(i);
          w_hi_found = 1'b1;
        end else begin
          w_lo_idx = SEL_W'(i);
        end
      end
    end
  end

  assign w_next_sel = w_hi_found ? w_hi_idx : w_lo_idx;

  // Entering SCAN from MANUAL always starts a fresh dwell.
  assign w_dwell_eff  = (r_state == ST_SCAN) ? r_dwell_cnt : '0;
  assign w_dwell_last = (w_dwell_eff == DCW'(DWELL - 1));

  always_comb begin
    w_state_nxt   = r_state;
    w_y_nxt       = r_y;
    w_y_valid_nxt = 1'b0;
    w_cur_sel_nxt = r_cur_sel;
    w_wrap_nxt    = 1'b0;
    w_sel_err_nxt = r_sel_err;
    w_dwell_nxt   = r_dwell_cnt;

    if (en) begin
      if (!mode) begin
        w_state_nxt = ST_MANUAL;
        w_dwell_nxt = '0;
        if (w_sel_ok) begin
          w_cur_sel_nxt = sel_in;
          w_y_nxt       = w_sel_data;
          w_y_valid_nxt = 1'b1;
          w_sel_err_nxt = 1'b0;
        end else begin
          w_y_nxt       = '0;
          w_sel_err_nxt = 1'b1;
        end
      end else begin
        w_state_nxt   = ST_SCAN;
        w_sel_err_nxt = 1'b0;
        // y tracks the selected channel live while it dwells.
        w_y_nxt       = w_cur_data;
        w_y_valid_nxt = w_cur_mask;
        if (ch_mask == '0) begin
          w_dwell_nxt = '0;
        end else if (!w_cur_mask || w_dwell_last) begin
          // A masked-off current channel is left at once, without waiting
          // out the dwell.
          w_dwell_nxt   = '0;
          w_cur_sel_nxt = w_next_sel;
          w_wrap_nxt    = !w_hi_found;
        end else begin
          w_dwell_nxt = w_dwell_eff + 1'b1;
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_MANUAL;
      r_y         <= '0;
      r_y_valid   <= 1'b0;
      r_cur_sel   <= '0;
      r_wrap      <= 1'b0;
      r_sel_err   <= 1'b0;
      r_dwell_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_y         <= w_y_nxt;
      r_y_valid   <= w_y_valid_nxt;
      r_cur_sel   <= w_cur_sel_nxt;
      r_wrap      <= w_wrap_nxt;
      r_sel_err   <= w_sel_err_nxt;
      r_dwell_cnt <= w_dwell_nxt;
    end
  end

  assign y       = r_y;
  assign y_valid = r_y_valid;
  assign cur_sel = r_cur_sel;
  assign wrap    = r_wrap;
  assign sel_err = r_sel_err;

endmodule

// File: tb/tb_scan_mux.sv
// -----------------------------------------------------------------------------
// tb_scan_mux
//   Self-checking bench for scan_mux. A 4-channel instance is tracked cycle by
//   cycle against a behavioural model through a scoreboard queue; a 5-channel
//   instance covers the out-of-range select and single-channel scan cases.
// -----------------------------------------------------------------------------
module tb_scan_mux;

  localparam int DWELL = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        mode;

  logic [1:0]  sel_in;
  logic [3:0]  ch_mask;
  logic [31:0] din;
  logic [7:0]  y;
  logic        y_valid;
  logic [1:0]  cur_sel;
  logic        wrap;
  logic        sel_err;

  logic [2:0]  sel5;
  logic [4:0]  mask5;
  logic [39:0] din5;
  logic [7:0]  y5;
  logic        y_valid5;
  logic [2:0]  cur_sel5;
  logic        wrap5;
  logic        sel_err5;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [7:0] y;
    logic       valid;
    logic [1:0] sel;
    logic       wrap;
    logic       err;
  } exp_t;

  exp_t sb[$];

  // Reference model state for the 4-channel instance.
  logic [7:0] m_y;
  bit         m_valid, m_wrap, m_err, m_scan;
  int         m_sel, m_dwell;

  always #5 clk = ~clk;

  scan_mux #(.N_CH(4), .DW(8), .DWELL(DWELL)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode),
    .sel_in(sel_in), .ch_mask(ch_mask), .din(din),
    .y(y), .y_valid(y_valid), .cur_sel(cur_sel), .wrap(wrap), .sel_err(sel_err)
  );

  scan_mux #(.N_CH(5), .DW(8), .DWELL(DWELL)) u_dut5 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode),
    .sel_in(sel5), .ch_mask(mask5), .din(din5),
    .y(y5), .y_valid(y_valid5), .cur_sel(cur_sel5), .wrap(wrap5), .sel_err(sel_err5)
  );

  task automatic model_reset();
    m_y = '0; m_valid = 0; m_wrap = 0; m_err = 0; m_scan = 0;
    m_sel = 0; m_dwell = 0;
    sb.delete();
  endtask

  // Predict the outputs after the coming edge from the inputs now applied.
  task automatic model_push();
    exp_t e;
    int   d, nxt, idx, s;
    bit   found;
    if (!en) begin
      m_valid = 0;
      m_wrap  = 0;
    end else if (!mode) begin
      s       = int'(sel_in);
      m_scan  = 0;
      m_dwell = 0;
      m_wrap  = 0;
      m_sel   = s;
      m_y     = din[s*8 +: 8];
      m_valid = 1;
      m_err   = 0;
    end else begin
      d       = m_scan ? m_dwell : 0;
      m_err   = 0;
      m_wrap  = 0;
      m_y     = din[m_sel*8 +: 8];
      m_valid = ch_mask[m_sel];
      if (ch_mask == 4'b0000) begin
        m_dwell = 0;
      end else if (!ch_mask[m_sel] || d == DWELL - 1) begin
        nxt   = m_sel;
        found = 0;
        for (int k = 1; k <= 4; k++) begin
          idx = (m_sel + k) % 4;
          if (!found && ch_mask[idx]) begin
            nxt   = idx;
            found = 1;
          end
        end
        m_wrap  = (nxt <= m_sel);
        m_sel   = nxt;
        m_dwell = 0;
      end else begin
        m_dwell = d + 1;
      end
      m_scan = 1;
    end
    e.y     = m_y;
    e.valid = m_valid;
    e.sel   = 2'(m_sel);
    e.wrap  = m_wrap;
    e.err   = m_err;
    sb.push_back(e);
  endtask

  // One clock: predict, clock, then compare the 4-channel outputs.
  task automatic cycle(input string tag);
    exp_t e;
    model_push();
    @(posedge clk);
    #1;
    e = sb.pop_front();
    checks++;
    if (y !== e.y || y_valid !== e.valid || cur_sel !== e.sel ||
        wrap !== e.wrap || sel_err !== e.err) begin
      errors++;
      $display("FAIL %s t=%0t got y=%h v=%b sel=%0d wrap=%b err=%b want y=%h v=%b sel=%0d wrap=%b err=%b",
               tag, $time, y, y_valid, cur_sel, wrap, sel_err,
               e.y, e.valid, e.sel, e.wrap, e.err);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; mode = 1'b0;
    sel_in = '0; ch_mask = '0; din = '0;
    sel5 = '0; mask5 = '0; din5 = 40'h55_44_33_22_11;
    model_reset();
    #2;
    checks++;
    if ({y, y_valid, cur_sel, wrap, sel_err} !== 13'd0) begin
      errors++;
      $display("FAIL reset4 got y=%h v=%b sel=%0d wrap=%b err=%b want all 0",
               y, y_valid, cur_sel, wrap, sel_err);
    end
    checks++;
    if ({y5, y_valid5, cur_sel5, wrap5, sel_err5} !== 14'd0) begin
      errors++;
      $display("FAIL reset5 got y=%h v=%b sel=%0d wrap=%b err=%b want all 0",
               y5, y_valid5, cur_sel5, wrap5, sel_err5);
    end
    #6 rst_n = 1'b1;
  endtask

  task automatic test_manual();
    logic [7:0] exp_man [4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    en  = 1'b1;
    mode = 1'b0;
    din = 32'hDD_CC_BB_AA;
    for (int s = 0; s < 4; s++) begin
      sel_in = 2'(s);
      cycle("manual_sb");
      checks++;
      if (y !== exp_man[s] || y_valid !== 1'b1) begin
        errors++;
        $display("FAIL manual sel=%0d got y=%h v=%b want y=%h v=1", s, y, y_valid, exp_man[s]);
      end
    end
  endtask

  task automatic test_scan();
    int exp_seq [16] = '{0, 0, 0, 1, 1, 1, 1, 3, 3, 3, 3, 0, 0, 0, 0, 1};
    sel_in = 2'd0;
    cycle("scan_pre");
    mode    = 1'b1;
    ch_mask = 4'b1011;
    for (int k = 1; k <= 16; k++) begin
      din = $urandom;
      cycle("scan_sb");
      checks++;
      if (cur_sel !== 2'(exp_seq[k-1]) || wrap !== (k == 12) || cur_sel === 2'd2) begin
        errors++;
        $display("FAIL scan_seq k=%0d got sel=%0d wrap=%b want sel=%0d wrap=%b",
                 k, cur_sel, wrap, exp_seq[k-1], (k == 12));
      end
    end
  endtask

  task automatic test_mask0();
    logic [1:0] held;
    held    = cur_sel;
    ch_mask = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      cycle("mask0_sb");
      checks++;
      if (y_valid !== 1'b0 || cur_sel !== held || wrap !== 1'b0) begin
        errors++;
        $display("FAIL mask0 got v=%b sel=%0d wrap=%b want v=0 sel=%0d wrap=0",
                 y_valid, cur_sel, wrap, held);
      end
    end
    ch_mask = 4'b0100;
    cycle("mask1_sb");
    checks++;
    if (cur_sel !== 2'd2) begin
      errors++;
      $display("FAIL mask_single_jump got sel=%0d want 2", cur_sel);
    end
    for (int k = 1; k <= 8; k++) begin
      cycle("mask1_sb");
      checks++;
      if (cur_sel !== 2'd2 || wrap !== (k == 4 || k == 8)) begin
        errors++;
        $display("FAIL mask_single_wrap k=%0d got sel=%0d wrap=%b want sel=2 wrap=%b",
                 k, cur_sel, wrap, (k == 4 || k == 8));
      end
    end
  endtask

  task automatic test_en_hold();
    logic [1:0] prev, hs;
    logic [7:0] hy;
    bit         moved;
    ch_mask = 4'b1111;
    prev    = cur_sel;
    moved   = 0;
    for (int k = 0; k < 10 && !moved; k++) begin
      cycle("en_wait");
      if (cur_sel !== prev) moved = 1;
    end
    checks++;
    if (!moved) begin
      errors++;
      $display("FAIL en_wait_timeout got sel=%0d want a channel change within 10 clk", cur_sel);
    end
    cycle("en_pre");
    hy = y;
    hs = cur_sel;
    en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      din = $urandom;
      cycle("en_off_sb");
      checks++;
      if (y !== hy || cur_sel !== hs || y_valid !== 1'b0) begin
        errors++;
        $display("FAIL en_hold got y=%h sel=%0d v=%b want y=%h sel=%0d v=0",
                 y, cur_sel, y_valid, hy, hs);
      end
    end
    en = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      cycle("en_resume_sb");
      checks++;
      if ((k < 3 && cur_sel !== hs) || (k == 3 && cur_sel !== hs + 2'd1)) begin
        errors++;
        $display("FAIL en_resume k=%0d got sel=%0d want %0d",
                 k, cur_sel, (k < 3) ? hs : hs + 2'd1);
      end
    end
  endtask

  task automatic test_n5();
    mode = 1'b0;
    sel5 = 3'd6;
    cycle("n5_manual_sb");
    checks++;
    if (sel_err5 !== 1'b1 || y5 !== 8'h00 || y_valid5 !== 1'b0) begin
      errors++;
      $display("FAIL n5_sel_err got err=%b y=%h v=%b want err=1 y=00 v=0", sel_err5, y5, y_valid5);
    end
    mode  = 1'b1;
    mask5 = 5'b10000;
    cycle("n5_scan_sb");
    checks++;
    if (cur_sel5 !== 3'd4 || wrap5 !== 1'b0 || sel_err5 !== 1'b0) begin
      errors++;
      $display("FAIL n5_jump got sel=%0d wrap=%b err=%b want sel=4 wrap=0 err=0",
               cur_sel5, wrap5, sel_err5);
    end
    for (int k = 1; k <= 4; k++) begin
      cycle("n5_dwell_sb");
      checks++;
      if (cur_sel5 !== 3'd4 || wrap5 !== (k == 4) || y5 !== 8'h55 || y_valid5 !== 1'b1) begin
        errors++;
        $display("FAIL n5_dwell k=%0d got sel=%0d wrap=%b y=%h v=%b want sel=4 wrap=%b y=55 v=1",
                 k, cur_sel5, wrap5, y5, y_valid5, (k == 4));
      end
    end
  endtask

  task automatic test_async_reset();
    en      = 1'b1;
    mode    = 1'b1;
    ch_mask = 4'b1011;
    din     = 32'hDD_CC_BB_AA;
    for (int k = 0; k < 6; k++) cycle("ar_pre_sb");
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if ({y, y_valid, cur_sel, wrap, sel_err} !== 13'd0) begin
      errors++;
      $display("FAIL async_reset4 got y=%h v=%b sel=%0d wrap=%b want all 0",
               y, y_valid, cur_sel, wrap);
    end
    checks++;
    if ({y5, y_valid5, cur_sel5, wrap5, sel_err5} !== 14'd0) begin
      errors++;
      $display("FAIL async_reset5 got y=%h v=%b sel=%0d wrap=%b want all 0",
               y5, y_valid5, cur_sel5, wrap5);
    end
    model_reset();
    #2 rst_n = 1'b1;
    for (int k = 0; k < 6; k++) cycle("ar_post_sb");
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 60; k++) begin
      en      = ($urandom_range(0, 7) != 0);
      mode    = ($urandom_range(0, 2) != 0);
      sel_in  = 2'($urandom_range(0, 3));
      ch_mask = (k % 10 < 2) ? 4'($urandom_range(0, 15)) : ch_mask;
      din     = $urandom;
      cycle("random_sb");
    end
  endtask

  initial begin
    test_reset();
    test_manual();
    test_scan();
    test_mask0();
    test_en_hold();
    test_n5();
    test_async_reset();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
